bp_cfg_loader: RTL
==================

BP_CFG_LOADER -- requirements
Module: bp_cfg_loader

Interface
REQ-001 SHALL have parameter num_core_p, default 1, number of target cores (1..2**cfg_core_width_p).
REQ-002 SHALL have parameter cfg_core_width_p, default 8, core-id field width.
REQ-003 SHALL have parameter cfg_addr_width_p, default 16, config register address width.
REQ-004 SHALL have parameter cfg_data_width_p, default 32, config data width.
REQ-005 SHALL have parameter max_entries_p, default 16, table depth; lg_entries = `BSG_SAFE_CLOG2(max_entries_p+1).
REQ-006 SHALL have clk_i, input, 1, sole clock; all state changes on its rising edge.
REQ-007 SHALL have reset_i, input, 1, reset; asynchronous, active-high.
REQ-008 SHALL have start_i, input, 1, one-cycle pulse launching a load sequence.
REQ-009 SHALL have num_entries_i, input, lg_entries, entries to process; sampled on the accepted start_i; values above max_entries_p are clamped to max_entries_p.
REQ-010 SHALL have tbl_idx_o, output, `BSG_SAFE_CLOG2(max_entries_p), table read index.
REQ-011 SHALL have tbl_bcast_i, tbl_core_i, tbl_addr_i, tbl_data_i as inputs of width 1, cfg_core_width_p, cfg_addr_width_p and cfg_data_width_p, carrying the combinational table entry at tbl_idx_o.
REQ-012 SHALL have cfg_v_o (1), cfg_core_o, cfg_addr_o and cfg_data_o as outputs forming the config write packet, and cfg_ready_i (1) as input.
REQ-013 SHALL have busy_o (1), done_o (1) and writes_o (cfg_core_width_p+lg_entries), all outputs; writes_o is the count of accepted writes.

Function
REQ-014 SHALL implement the states e_idle, e_fetch, e_send and e_done.
REQ-015 In e_idle, start_i SHALL latch the clamped entry count, zero idx, core and writes_o, then go to e_fetch, or to e_done directly if the count is 0.
REQ-016 In e_fetch, the loader SHALL register the table entry at tbl_idx_o into a packet register.
- Core field = 0 if bcast, else tbl_core_i.
- Next state: e_send.
REQ-017 In e_send, cfg_v_o SHALL be 1.
- Packet SHALL stay stable until cfg_v_o & cfg_ready_i.
- cfg_v_o SHALL NOT depend combinationally on cfg_ready_i.
REQ-018 On a handshake, writes_o SHALL increment by 1.
REQ-019 On a handshake with bcast set and core < num_core_p-1, core SHALL increment and the state SHALL remain e_send, giving back-to-back writes at one per cycle while ready.
REQ-020 On any other handshake, the loader SHALL go to e_done if idx = count-1, else increment idx and go to e_fetch.
REQ-021 A unicast tbl_core_i >= num_core_p SHALL be skipped with no cfg_v_o and no writes_o increment, and the loader SHALL advance as in REQ-020.
REQ-022 In e_done, done_o SHALL be 1; start_i SHALL restart per REQ-015 in the same cycle.
REQ-023 start_i SHALL be ignored in e_fetch and e_send.
REQ-024 busy_o SHALL be 1 in e_fetch and e_send.
REQ-025 Per-entry latency SHALL be 1 fetch cycle plus the send cycles: minimum 2 cycles per unicast, 1+num_core_p per broadcast.
REQ-026 tbl_idx_o SHALL equal the registered idx in all states.

Reset
REQ-027 When reset_i is asserted, state SHALL become e_idle immediately.
- cfg_v_o, busy_o, done_o, writes_o, idx, core and count SHALL all be 0.
- This SHALL hold even mid-sequence, and any in-flight packet SHALL be dropped.
REQ-028 start_i coincident with reset_i SHALL be ignored.

Structure
REQ-029 The state enum bp_cfg_loader_state_e and the packet struct bp_cfg_bus_s (core, addr, data) SHALL be defined in bp_common_pkg, sized by macro from the cfg widths.
REQ-030 The idx counter SHALL be an instance of bsg_counter_clear_up; the remaining logic SHALL be inline.

Verification
REQ-031 num_core_p=4, count=2, entries {bcast,0x0010,0xA} and {unicast core2,0x0020,0xB}, ready=1 -> writes (0,0x10,A),(1,0x10,A),(2,0x10,A),(3,0x10,A), then after one fetch cycle (2,0x20,B); writes_o=5; done_o=1.
REQ-032 Same stimulus with ready toggling 1/0 each cycle -> identical packet sequence; each packet holds stable while ready=0.
REQ-033 count=0 -> done_o=1 on the next cycle; cfg_v_o never asserts; writes_o=0.
REQ-034 num_core_p=2, unicast core 5 followed by unicast core 1 -> only (1,...) is issued; writes_o=1.
REQ-035 reset_i asserted during the second broadcast write -> cfg_v_o=0 immediately; a later start_i with count=1 replays from idx 0.
REQ-036 num_entries_i=20 with max_entries_p=16 -> exactly 16 entries are processed; start_i pulsed mid-sequence has no effect.

Source files
------------

// File: rtl/bp_common_pkg.sv
// Shared types for the BlackParrot config-bus blocks: loader state encoding,
// config-bus packet layout, and the width helper macros used to size them.

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

// Declares bp_cfg_bus_s for a given set of config widths so each module can
// size the packet from its own parameters.
`ifndef BP_DECLARE_CFG_BUS_S
`define BP_DECLARE_CFG_BUS_S(core_width_mp, addr_width_mp, data_width_mp) \
  typedef struct packed {                                                   \
    logic [core_width_mp-1:0] core;                                         \
    logic [addr_width_mp-1:0] addr;                                         \
    logic [data_width_mp-1:0] data;                                         \
  } bp_cfg_bus_s
`endif

package bp_common_pkg;

  // Loader sequencing states
  typedef enum logic [1:0] {
    e_idle,
    e_fetch,
    e_send,
    e_done
  } bp_cfg_loader_state_e;

  // Default config-bus widths
  localparam int cfg_core_width_gp = 8;
  localparam int cfg_addr_width_gp = 16;
  localparam int cfg_data_width_gp = 32;

  // Packet at the default widths; parameterised modules redeclare it locally
  `BP_DECLARE_CFG_BUS_S(cfg_core_width_gp, cfg_addr_width_gp, cfg_data_width_gp);

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with a clear that restarts from init_val_p; clear and up in the
// same cycle yield init_val_p + 1.

module bsg_counter_clear_up #(
  parameter int max_val_p  = 15,
  parameter int init_val_p = 0,
  parameter int width_p    = `BSG_SAFE_CLOG2(max_val_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  // Count register: reset/clear to init value, otherwise step on up_i
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      // NOTE: state registers take non-blocking assignments so every flop
      // samples the pre-edge values, independent of block ordering.
      count_o <= width_p'(init_val_p);
    end else if (clear_i) begin
      count_o <= width_p'(init_val_p) + width_p'(up_i);
    end else if (up_i) begin
      count_o <= count_o + width_p'(1);
    end
  end

endmodule

// File: rtl/bp_cfg_loader.sv
// Config loader: walks a combinational table of config entries and issues one
// config-bus write per entry, or one write per core for broadcast entries.
// Unicast entries naming a nonexistent core are skipped silently.

module bp_cfg_loader
  import bp_common_pkg::*;
#(
  parameter int num_core_p       = 1,
  parameter int cfg_core_width_p = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32,
  parameter int max_entries_p    = 16,
  localparam int lg_entries_lp   = `BSG_SAFE_CLOG2(max_entries_p + 1),
  localparam int lg_idx_lp       = `BSG_SAFE_CLOG2(max_entries_p),
  localparam int writes_width_lp = cfg_core_width_p + lg_entries_lp
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        start_i,
  input  logic [lg_entries_lp-1:0]    num_entries_i,

  output logic [lg_idx_lp-1:0]        tbl_idx_o,
  input  logic                        tbl_bcast_i,
  input  logic [cfg_core_width_p-1:0] tbl_core_i,
  input  logic [cfg_addr_width_p-1:0] tbl_addr_i,
  input  logic [cfg_data_width_p-1:0] tbl_data_i,

  output logic                        cfg_v_o,
  output logic [cfg_core_width_p-1:0] cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ready_i,

  output logic                        busy_o,
  output logic                        done_o,
  output logic [writes_width_lp-1:0]  writes_o
);

  `BP_DECLARE_CFG_BUS_S(cfg_core_width_p, cfg_addr_width_p, cfg_data_width_p);

  localparam logic [cfg_core_width_p-1:0] last_core_lp   = cfg_core_width_p'(num_core_p - 1);
  localparam logic [cfg_core_width_p:0]   num_core_lp    = (cfg_core_width_p + 1)'(num_core_p);
  localparam logic [lg_entries_lp-1:0]    max_entries_lp = lg_entries_lp'(max_entries_p);

  bp_cfg_loader_state_e state_r, state_n;

  logic [lg_entries_lp-1:0]   count_r;
  bp_cfg_bus_s                pkt_r;
  logic                       bcast_r;
  logic [writes_width_lp-1:0] writes_r;

  logic                     start_accept;
  logic [lg_entries_lp-1:0] count_clamped;
  logic                     handshake;
  logic                     bcast_more;
  logic                     entry_skip;
  logic                     entry_done;
  logic                     last_entry;
  logic                     idx_up;

  assign start_accept  = start_i & ((state_r == e_idle) | (state_r == e_done));
  assign count_clamped = (num_entries_i > max_entries_lp) ? max_entries_lp : num_entries_i;
  assign handshake     = (state_r == e_send) & cfg_ready_i;
  assign bcast_more    = bcast_r & (pkt_r.core < last_core_lp);
  assign entry_skip    = (state_r == e_fetch) & ~tbl_bcast_i
                       & ({1'b0, tbl_core_i} >= num_core_lp);
  assign entry_done    = entry_skip | (handshake & ~bcast_more);
  assign last_entry    = (lg_entries_lp'(tbl_idx_o) + lg_entries_lp'(1)) == count_r;
  assign idx_up        = entry_done & ~last_entry;

  // Table index: restarts on an accepted start, steps when an entry retires
  bsg_counter_clear_up #(
    .max_val_p (max_entries_p - 1),
    .init_val_p(0),
    .width_p   (lg_idx_lp)
  ) idx_counter (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(start_accept),
    .up_i   (idx_up),
    .count_o(tbl_idx_o)
  );

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns state_n and no latch is inferred.
    state_n = state_r;
    unique case (state_r)
      e_idle, e_done: begin
        if (start_i) state_n = (count_clamped == '0) ? e_done : e_fetch;
      end
      e_fetch: begin
        if (entry_skip) state_n = last_entry ? e_done : e_fetch;
        else            state_n = e_send;
      end
      e_send: begin
        if (handshake & ~bcast_more) state_n = last_entry ? e_done : e_fetch;
      end
      default: state_n = e_idle;
    endcase
  end

  // State-decoded outputs; cfg_v_o depends on state only, never on ready
  always_comb begin
    cfg_v_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_r)
      e_fetch: busy_o = 1'b1;
      e_send: begin
        busy_o  = 1'b1;
        cfg_v_o = 1'b1;
      end
      e_done:  done_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath: entry count, packet register, broadcast flag and write counter
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      // NOTE: the packet register is plain flops, not a memory, so it is reset
      // along with the control state and an in-flight packet is discarded.
      count_r  <= '0;
      pkt_r    <= '0;
      bcast_r  <= 1'b0;
      writes_r <= '0;
    end else begin
      if (start_accept) begin
        count_r    <= count_clamped;
        pkt_r.core <= '0;
        writes_r   <= '0;
      end
      if (state_r == e_fetch) begin
        pkt_r.core <= tbl_bcast_i ? '0 : tbl_core_i;
        pkt_r.addr <= tbl_addr_i;
        pkt_r.data <= tbl_data_i;
        bcast_r    <= tbl_bcast_i;
      end
      if (handshake) begin
        writes_r <= writes_r + writes_width_lp'(1);
        if (bcast_more) pkt_r.core <= pkt_r.core + cfg_core_width_p'(1);
      end
    end
  end

  assign cfg_core_o = pkt_r.core;
  assign cfg_addr_o = pkt_r.addr;
  assign cfg_data_o = pkt_r.data;
  assign writes_o   = writes_r;

endmodule
